// File: rtl/mna_pkg.sv
// Shared definitions for the MNA request path: FSM states, header field layout, flit counts.
package mna_pkg;

    localparam int unsigned FLIT_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEST_W = 4;
    localparam int unsigned SRC_W  = 4;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned STRB_W = 4;

    localparam int unsigned HDR_DEST_LSB = 28;
    localparam int unsigned HDR_SRC_LSB  = 24;
    localparam int unsigned HDR_RD_BIT   = 23;
    localparam int unsigned HDR_LEN_LSB  = 20;
    localparam int unsigned HDR_STRB_LSB = 0;

    localparam int unsigned WR_FLITS = 3;
    localparam int unsigned RD_FLITS = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_ADDR,
        ST_DATA,
        ST_WAIT_RESP
    } state_t;

    // Header flit; reserved bits between LEN and STRB stay zero.
    function automatic logic [FLIT_W-1:0] make_header(
        input logic [DEST_W-1:0] dest,
        input logic [SRC_W-1:0]  src,
        input logic              rd,
        input logic [STRB_W-1:0] strb
    );
        logic [FLIT_W-1:0] h;
        h = '0;
        h[HDR_DEST_LSB +: DEST_W] = dest;
        h[HDR_SRC_LSB +: SRC_W]   = src;
        h[HDR_RD_BIT]             = rd;
        h[HDR_LEN_LSB +: LEN_W]   = rd ? LEN_W'(RD_FLITS - 1) : LEN_W'(WR_FLITS - 1);
        h[HDR_STRB_LSB +: STRB_W] = strb;
        return h;
    endfunction

endpackage

// File: rtl/mna_req_arbiter.sv
// Two-requester round-robin arbiter (write vs read); pointer flips on every grant.
module mna_req_arbiter (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic wr_req,
    input  logic rd_req,
    output logic wr_gnt_c,
    output logic rd_gnt_c
);

    logic prefer_rd;

    assign wr_gnt_c = en & wr_req & (~rd_req | ~prefer_rd);
    assign rd_gnt_c = en & rd_req & (~wr_req | prefer_rd);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prefer_rd <= 1'b0;
        end else if (wr_gnt_c | rd_gnt_c) begin
            prefer_rd <= ~prefer_rd;
        end
    end

endmodule

// File: rtl/mna_request_packetizer.sv
// MNA request side: AXI4-Lite slave that turns one AW+W or AR request into a NoC packet.
// Define MNA_REQ_WSTRB_EN to carry write strobes in header bits [3:0].
module mna_request_packetizer
    import mna_pkg::*;
#(
    parameter logic [SRC_W-1:0] SRC_ID   = 4'h0,
    parameter int unsigned      DEST_LSB = 28
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [FLIT_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    input  logic [7:0]        is_allocatable,
    input  logic [7:0]        is_on_off,
    input  logic              resp_done,
    output logic [FLIT_W-1:0] flit_data,
    output logic              flit_valid,
    output logic              flit_tail,
    output logic              busy
);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [FLIT_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic                rd_q;

    logic                wr_gnt_c;
    logic                rd_gnt_c;
    logic [ADDR_W-1:0]   grant_addr;
    logic [STRB_W-1:0]   grant_strb;
    logic [FLIT_W-1:0]   grant_hdr;
    logic [FLIT_W-1:0]   held_hdr;
    logic                alloc;
    logic                on;
    logic                unused_bits;

    assign alloc = is_allocatable[0];
    assign on    = is_on_off[0];

    mna_req_arbiter u_arb (
        .clock    (clock),
        .reset    (reset),
        .en       (state == ST_IDLE),
        .wr_req   (awvalid & wvalid),
        .rd_req   (arvalid),
        .wr_gnt_c (wr_gnt_c),
        .rd_gnt_c (rd_gnt_c)
    );

    assign awready = wr_gnt_c;
    assign wready  = wr_gnt_c;
    assign arready = rd_gnt_c;

`ifdef MNA_REQ_WSTRB_EN
    assign grant_strb  = rd_gnt_c ? 4'hF : wstrb;
    assign unused_bits = ^{is_allocatable[7:1], is_on_off[7:1]};
`else
    assign grant_strb  = '0;
    assign unused_bits = ^{is_allocatable[7:1], is_on_off[7:1], wstrb};
`endif

    // Header can go out straight from the grant cycle when the VC is already allocatable.
    assign grant_addr = rd_gnt_c ? araddr : awaddr;
    assign grant_hdr  = make_header(grant_addr[DEST_LSB +: DEST_W], SRC_ID, rd_gnt_c, grant_strb);
    assign held_hdr   = make_header(addr_q[DEST_LSB +: DEST_W], SRC_ID, rd_q, strb_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            flit_valid <= 1'b0;
            flit_tail  <= 1'b0;
            flit_data  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            rd_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_gnt_c | rd_gnt_c) begin
                        busy    <= 1'b1;
                        rd_q    <= rd_gnt_c;
                        addr_q  <= grant_addr;
                        strb_q  <= grant_strb;
                        state   <= ST_HEAD;
                        if (wr_gnt_c) begin
                            wdata_q <= wdata;
                        end
                        if (alloc) begin
                            flit_valid <= 1'b1;
                            flit_data  <= grant_hdr;
                        end
                    end
                end
                ST_HEAD: begin
                    if (!flit_valid) begin
                        if (alloc) begin
                            flit_valid <= 1'b1;
                            flit_data  <= held_hdr;
                        end
                    end else if (on) begin
                        flit_data <= addr_q;
                        flit_tail <= rd_q;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (on) begin
                        if (rd_q) begin
                            flit_valid <= 1'b0;
                            flit_tail  <= 1'b0;
                            flit_data  <= '0;
                            state      <= ST_WAIT_RESP;
                        end else begin
                            flit_data <= wdata_q;
                            flit_tail <= 1'b1;
                            state     <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (on) begin
                        flit_valid <= 1'b0;
                        flit_tail  <= 1'b0;
                        flit_data  <= '0;
                        state      <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (resp_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mna_request_packetizer.sv
// Directed bench for mna_request_packetizer: vector table plus stall, allocation, arbitration and reset sequences.
module tb_mna_request_packetizer;

    logic        clock;
    logic        reset;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [7:0]  is_allocatable;
    logic [7:0]  is_on_off;
    logic        resp_done;
    logic [31:0] flit_data;
    logic        flit_valid;
    logic        flit_tail;
    logic        busy;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] hdr;
    } vec_t;

    vec_t vecs [5];

    mna_request_packetizer #(.SRC_ID(4'h2), .DEST_LSB(28)) dut (
        .clock          (clock),
        .reset          (reset),
        .awaddr         (awaddr),
        .awvalid        (awvalid),
        .awready        (awready),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .wvalid         (wvalid),
        .wready         (wready),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .is_allocatable (is_allocatable),
        .is_on_off      (is_on_off),
        .resp_done      (resp_done),
        .flit_data      (flit_data),
        .flit_valid     (flit_valid),
        .flit_tail      (flit_tail),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Header strobe field as the selected build should produce it.
    function automatic logic [31:0] sfield(input logic rd, input logic [3:0] s);
`ifdef MNA_REQ_WSTRB_EN
        return rd ? 32'h0000_000F : {28'h0, s};
`else
        return (rd | ^s) ? 32'h0 : 32'h0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic chk_flit(input string name, input logic [31:0] d, input logic tail);
        chk({name, ".valid"}, 32'(flit_valid), 32'd1);
        chk({name, ".data"}, flit_data, d);
        chk({name, ".tail"}, 32'(flit_tail), 32'(tail));
    endtask

    task automatic pulse_resp(input string name);
        resp_done = 1'b1;
        @(negedge clock);
        resp_done = 1'b0;
        chk({name, ".busy_clr"}, 32'(busy), 32'd0);
    endtask

    // One request with allocation and credit always available; starts and ends on a falling edge.
    task automatic do_txn(input string name, input vec_t v);
        if (v.rd) begin
            arvalid = 1'b1;
            araddr  = v.addr;
        end else begin
            awvalid = 1'b1;
            wvalid  = 1'b1;
            awaddr  = v.addr;
            wdata   = v.data;
            wstrb   = v.strb;
        end
        #1;
        chk({name, ".ready"}, 32'(v.rd ? arready : (awready & wready)), 32'd1);
        @(negedge clock);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        chk({name, ".busy"}, 32'(busy), 32'd1);
        chk_flit({name, ".hdr"}, v.hdr, 1'b0);
        @(negedge clock);
        chk_flit({name, ".addr"}, v.addr, v.rd);
        if (!v.rd) begin
            @(negedge clock);
            chk_flit({name, ".data"}, v.data, 1'b1);
        end
        @(negedge clock);
        chk({name, ".idle_valid"}, 32'(flit_valid), 32'd0);
        chk({name, ".wait_busy"}, 32'(busy), 32'd1);
        pulse_resp(name);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        araddr = '0; arvalid = 1'b0; resp_done = 1'b0;
        is_allocatable = 8'h01;
        is_on_off      = 8'h01;

        vecs[0] = '{rd: 1'b0, addr: 32'h3000_0010, data: 32'hDEAD_BEEF, strb: 4'hF, hdr: 32'h3220_0000 | sfield(1'b0, 4'hF)};
        vecs[1] = '{rd: 1'b1, addr: 32'h5000_0004, data: 32'h0,         strb: 4'h0, hdr: 32'h5290_0000 | sfield(1'b1, 4'h0)};
        vecs[2] = '{rd: 1'b0, addr: 32'hA123_4568, data: 32'h0123_4567, strb: 4'h3, hdr: 32'hA220_0000 | sfield(1'b0, 4'h3)};
        vecs[3] = '{rd: 1'b1, addr: 32'hF000_0000, data: 32'h0,         strb: 4'h0, hdr: 32'hF290_0000 | sfield(1'b1, 4'h0)};
        vecs[4] = '{rd: 1'b0, addr: 32'h0000_0000, data: 32'hFFFF_FFFF, strb: 4'h1, hdr: 32'h0220_0000 | sfield(1'b0, 4'h1)};

        @(negedge clock);
        chk("rst.valid", 32'(flit_valid), 32'd0);
        chk("rst.tail", 32'(flit_tail), 32'd0);
        chk("rst.data", flit_data, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ready", 32'({awready, wready, arready}), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Simultaneous requests straight after reset: write first, then read.
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h3000_0010; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h7000_0008;
        #1;
        chk("sim.awready", 32'(awready), 32'd1);
        chk("sim.arready0", 32'(arready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("sim.no_ready", 32'({awready, wready, arready}), 32'd0);
            if (i == 0) chk_flit("sim.hdr", vecs[0].hdr, 1'b0);
            if (i == 2) chk_flit("sim.data", 32'hDEAD_BEEF, 1'b1);
        end
        resp_done = 1'b1;
        @(negedge clock);
        resp_done = 1'b0;
        #1;
        chk("sim.arready1", 32'(arready), 32'd1);
        chk("sim.awready1", 32'(awready), 32'd0);
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk_flit("sim.rhdr", 32'h7290_0000 | sfield(1'b1, 4'h0), 1'b0);
        @(negedge clock);
        chk_flit("sim.raddr", 32'h7000_0008, 1'b1);
        @(negedge clock);
        pulse_resp("sim");
        @(negedge clock);

        for (int i = 0; i < 5; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i]);
            @(negedge clock);
        end

        // Read with the address flit stalled for 4 cycles; a stray resp_done must be ignored.
        arvalid = 1'b1; araddr = 32'h5000_0004;
        @(negedge clock);
        arvalid = 1'b0;
        chk_flit("stall.hdr", vecs[1].hdr, 1'b0);
        @(negedge clock);
        chk_flit("stall.addr0", 32'h5000_0004, 1'b1);
        is_on_off = 8'h00;
        for (int i = 1; i <= 4; i++) begin
            resp_done = (i == 1);
            @(negedge clock);
            resp_done = 1'b0;
            chk_flit($sformatf("stall.addr%0d", i), 32'h5000_0004, 1'b1);
            chk("stall.busy", 32'(busy), 32'd1);
        end
        is_on_off = 8'h01;
        @(negedge clock);
        chk("stall.done", 32'(flit_valid), 32'd0);
        pulse_resp("stall");
        @(negedge clock);

        // Allocation withheld for 6 cycles after the grant; later drops are ignored.
        is_allocatable = 8'h00;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'hA123_4568; wdata = 32'h0123_4567; wstrb = 4'h3;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            awvalid = 1'b0; wvalid = 1'b0;
            chk($sformatf("alloc.wait%0d", i), 32'(flit_valid), 32'd0);
        end
        is_allocatable = 8'hFF;
        @(negedge clock);
        is_allocatable = 8'hFE;
        chk_flit("alloc.hdr", vecs[2].hdr, 1'b0);
        @(negedge clock);
        chk_flit("alloc.addr", 32'hA123_4568, 1'b0);
        @(negedge clock);
        chk_flit("alloc.data", 32'h0123_4567, 1'b1);
        @(negedge clock);
        is_allocatable = 8'h01;
        pulse_resp("alloc");
        @(negedge clock);

        // Reset while the data flit is waiting for credit.
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'hA123_4568; wdata = 32'h0123_4567; wstrb = 4'h3;
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        is_on_off = 8'h00;
        chk_flit("mid.data", 32'h0123_4567, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid.valid", 32'(flit_valid), 32'd0);
        chk("mid.tail", 32'(flit_tail), 32'd0);
        chk("mid.fdata", flit_data, 32'd0);
        chk("mid.busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        is_on_off = 8'h01;
        @(negedge clock);
        do_txn("post_rst", vecs[0]);
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
